// File: rtl/sdram_di_port_ctrl_if.sv
// MCB user-port bundle (command, write FIFO, read FIFO) for one 32-bit Spartan-6 port.
// master = controller side, slave = MCB side.
interface sdram_di_port_ctrl_if;
    logic        p_cmd_en;
    logic [2:0]  p_cmd_instr;
    logic [5:0]  p_cmd_bl;
    logic [29:0] p_cmd_byte_addr;
    logic        p_cmd_full;
    logic        p_wr_en;
    logic [3:0]  p_wr_mask;
    logic [31:0] p_wr_data;
    logic        p_wr_full;
    logic        p_wr_underrun;
    logic        p_wr_error;
    logic        p_rd_en;
    logic [31:0] p_rd_data;
    logic        p_rd_empty;
    logic        p_rd_overflow;
    logic        p_rd_error;

    modport master (
        output p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
        output p_wr_en, p_wr_mask, p_wr_data,
        output p_rd_en,
        input  p_cmd_full, p_wr_full, p_wr_underrun, p_wr_error,
        input  p_rd_data, p_rd_empty, p_rd_overflow, p_rd_error
    );

    modport slave (
        input  p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr,
        input  p_wr_en, p_wr_mask, p_wr_data,
        input  p_rd_en,
        output p_cmd_full, p_wr_full, p_wr_underrun, p_wr_error,
        output p_rd_data, p_rd_empty, p_rd_overflow, p_rd_error
    );
endinterface

// File: rtl/sdram_di_port_ctrl.sv
// Host di_* block transfers to one MCB user port as bursts of up to BURST_LEN words.
// Optional command counters and status[15:8] when SDRAM_DI_STATS_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a write-mode rise or read request on our terminal
// WR_FILL  | pushing host words into the MCB write FIFO
// WR_CMD   | holding a write command until the command FIFO takes it
// RD_CMD   | holding a read command until the command FIFO takes it
// RD_DATA  | handing read-FIFO words to the host
// RD_FLUSH | read aborted: draining the rest of the outstanding burst
module sdram_di_port_ctrl #(
    parameter int          BURST_LEN = 32,
    parameter logic [15:0] TERM_ADDR = 16'h0010
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic [31:0] di_len,
    input  logic        di_read_mode,
    input  logic        di_read_req,
    input  logic        di_read,
    input  logic        di_write_mode,
    input  logic        di_write,
    input  logic [31:0] di_reg_datai,
    output logic        di_read_rdy,
    output logic [31:0] di_reg_datao,
    output logic        di_write_rdy,
    output logic [15:0] di_transfer_status,
    sdram_di_port_ctrl_if.master mcb
`ifdef SDRAM_DI_STATS_EN
    ,
    output logic [15:0] stat_wr_cmds,
    output logic [15:0] stat_rd_cmds
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FILL, S_WR_CMD, S_RD_CMD, S_RD_DATA, S_RD_FLUSH
    } state_t;

    localparam logic [6:0]  BL_W  = 7'(BURST_LEN);
    localparam logic [29:0] BL_30 = 30'(BURST_LEN);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [29:0] rem_q, rem_d;
    logic [6:0]  wcnt_q, wcnt_d;
    logic [6:0]  rcnt_q, rcnt_d;
    logic        wm_prev_q, wm_prev_d;
    logic [3:0]  status_q, status_d;

    logic        sel, wm_s, rm_s, rd_req_s, wr_s, rd_s, wr_rise;
    logic [32:0] len_sum;
    logic [29:0] nwords, start_addr;
    logic [6:0]  rd_burst, wcnt_m1, rburst_m1;
    logic [3:0]  err_evt;
    logic        start;

    logic        cmd_en, wr_rdy, rd_rdy, wr_en, rd_en;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_addr;
    logic [31:0] datao;
    logic        unused_ok;

    assign sel        = (di_term_addr == TERM_ADDR);
    assign wm_s       = sel & di_write_mode;
    assign rm_s       = sel & di_read_mode;
    assign rd_req_s   = sel & di_read_req;
    assign wr_s       = sel & di_write;
    assign rd_s       = sel & di_read;
    assign wr_rise    = wm_s & ~wm_prev_q;
    assign len_sum    = {1'b0, di_len} + 33'd3;
    assign nwords     = len_sum[31:2];
    assign start_addr = {di_reg_addr[29:2], 2'b00};
    assign rd_burst   = (rem_q >= BL_30) ? BL_W : rem_q[6:0];
    assign wcnt_m1    = wcnt_q - 7'd1;
    assign rburst_m1  = rd_burst - 7'd1;
    assign err_evt    = {mcb.p_rd_error, mcb.p_rd_overflow, mcb.p_wr_error, mcb.p_wr_underrun};
    assign unused_ok  = ^{len_sum[32], len_sum[1:0], di_reg_addr[31:30], di_reg_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        wm_prev_d = wm_s;
        start     = 1'b0;
        cmd_en    = 1'b0;
        cmd_instr = 3'b000;
        cmd_bl    = 6'd0;
        cmd_addr  = 30'd0;
        wr_rdy    = 1'b0;
        wr_en     = 1'b0;
        rd_rdy    = 1'b0;
        rd_en     = 1'b0;
        datao     = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (wr_rise && nwords != 30'd0) begin
                    addr_d  = start_addr;
                    rem_d   = nwords;
                    wcnt_d  = 7'd0;
                    start   = 1'b1;
                    state_d = S_WR_FILL;
                end else if (rd_req_s && nwords != 30'd0) begin
                    addr_d  = start_addr;
                    rem_d   = nwords;
                    rcnt_d  = 7'd0;
                    start   = 1'b1;
                    state_d = S_RD_CMD;
                end
            end
            S_WR_FILL: begin
                wr_rdy = ~mcb.p_wr_full & (wcnt_q < BL_W) & (rem_q != 30'd0);
                wr_en  = wr_s & wr_rdy;
                if (wr_en) begin
                    wcnt_d = wcnt_q + 7'd1;
                    rem_d  = rem_q - 30'd1;
                end
                // An abort still flushes whatever was already pushed as a short burst.
                if (!wm_s) begin
                    if (wcnt_d != 7'd0) begin
                        rem_d   = 30'd0;
                        state_d = S_WR_CMD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wcnt_q == BL_W || (rem_q == 30'd0 && wcnt_q != 7'd0)) begin
                    state_d = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                cmd_en    = 1'b1;
                cmd_instr = 3'b000;
                cmd_bl    = wcnt_m1[5:0];
                cmd_addr  = addr_q;
                if (!mcb.p_cmd_full) begin
                    addr_d  = addr_q + {21'd0, wcnt_q, 2'b00};
                    wcnt_d  = 7'd0;
                    state_d = (rem_q != 30'd0) ? S_WR_FILL : S_IDLE;
                end
            end
            S_RD_CMD: begin
                cmd_en    = 1'b1;
                cmd_instr = 3'b001;
                cmd_bl    = rburst_m1[5:0];
                cmd_addr  = addr_q;
                if (!mcb.p_cmd_full) begin
                    rcnt_d  = rd_burst;
                    addr_d  = addr_q + {21'd0, rd_burst, 2'b00};
                    rem_d   = rem_q - {23'd0, rd_burst};
                    // A command taken in the abort cycle still returns data that must be drained.
                    state_d = rm_s ? S_RD_DATA : S_RD_FLUSH;
                end else if (!rm_s) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_DATA: begin
                rd_rdy = ~mcb.p_rd_empty & (rcnt_q != 7'd0);
                datao  = mcb.p_rd_data;
                rd_en  = rd_s & rd_rdy;
                if (rd_en) rcnt_d = rcnt_q - 7'd1;
                if (!rm_s) begin
                    state_d = S_RD_FLUSH;
                end else if (rcnt_q == 7'd0) begin
                    state_d = (rem_q != 30'd0) ? S_RD_CMD : S_IDLE;
                end
            end
            S_RD_FLUSH: begin
                rd_en = ~mcb.p_rd_empty & (rcnt_q != 7'd0);
                if (rd_en) rcnt_d = rcnt_q - 7'd1;
                if (rcnt_q == 7'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        status_d = (start ? 4'd0 : status_q) | err_evt;
    end

`ifdef SDRAM_DI_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d;
    logic [7:0]  stat_sum;
    logic        cmd_acc;

    assign cmd_acc = cmd_en & ~mcb.p_cmd_full;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (cmd_acc && state_q == S_WR_CMD && stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
        if (cmd_acc && state_q == S_RD_CMD && stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
    end

    assign stat_sum           = stat_wr_q[7:0] + stat_rd_q[7:0];
    assign stat_wr_cmds       = stat_wr_q;
    assign stat_rd_cmds       = stat_rd_q;
    assign di_transfer_status = {stat_sum, 4'd0, status_q};
`else
    assign di_transfer_status = {12'd0, status_q};
`endif

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            addr_q    <= 30'd0;
            rem_q     <= 30'd0;
            wcnt_q    <= 7'd0;
            rcnt_q    <= 7'd0;
            wm_prev_q <= 1'b0;
            status_q  <= 4'd0;
`ifdef SDRAM_DI_STATS_EN
            stat_wr_q <= 16'd0;
            stat_rd_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            wm_prev_q <= wm_prev_d;
            status_q  <= status_d;
`ifdef SDRAM_DI_STATS_EN
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
`endif
        end
    end

    assign di_write_rdy        = wr_rdy;
    assign di_read_rdy         = rd_rdy;
    assign di_reg_datao        = datao;
    assign mcb.p_cmd_en        = cmd_en;
    assign mcb.p_cmd_instr     = cmd_instr;
    assign mcb.p_cmd_bl        = cmd_bl;
    assign mcb.p_cmd_byte_addr = cmd_addr;
    assign mcb.p_wr_en         = wr_en;
    assign mcb.p_wr_mask       = 4'd0;
    assign mcb.p_wr_data       = di_reg_datai;
    assign mcb.p_rd_en         = rd_en;

endmodule

// File: doc/sdram_di_port_ctrl.md
Name: sdram_di_port_ctrl

Overview:
- Sequences one Spartan-6 MCB user port (p1/p2/p3 style, 32-bit) on behalf of the host data interface (di_*).
- Turns host block writes and reads into MCB write and read bursts of up to BURST_LEN words, and tracks the MCB FIFO handshakes.
- Sits inside ProjectTop between the di_* mux (selected when di_term_addr equals its terminal) and one MCB port.
- The top level drives pX_clk from ifclk.

Parameters:
- BURST_LEN, 32: max words per MCB command, 1..64 (bl field = words-1).
- TERM_ADDR, 16'h0010: di_term_addr value that selects this block.

Ports:
- ifclk  in  1  system clock, 48 MHz.
- resetb  in  1  async active-low reset.
- di_term_addr  in  16  terminal select.
- di_reg_addr  in  32  start byte address; [29:0] used, [1:0] forced to 0.
- di_len  in  32  transfer length in bytes.
- di_read_mode  in  1  read transfer active.
- di_read_req  in  1  1-cycle pulse at start of read transfer.
- di_read  in  1  host pops one word.
- di_write_mode  in  1  write transfer active.
- di_write  in  1  host pushes one word.
- di_reg_datai  in  32  write word.
- di_read_rdy  out  1  read word valid.
- di_reg_datao  out  32  read word.
- di_write_rdy  out  1  write word accepted this cycle if di_write.
- di_transfer_status  out  16  0 = ok; error bits below.
- p_cmd_en  out  1  MCB command strobe.
- p_cmd_instr  out  3  000 write, 001 read.
- p_cmd_bl  out  6  burst length minus 1.
- p_cmd_byte_addr  out  30  burst byte address.
- p_cmd_full  in  1  MCB command FIFO full.
- p_wr_en  out  1  MCB write FIFO push.
- p_wr_mask  out  4  always 0.
- p_wr_data  out  32  equals di_reg_datai.
- p_wr_full  in  1  MCB write FIFO full.
- p_wr_underrun  in  1  MCB write underrun.
- p_wr_error  in  1  MCB write error.
- p_rd_en  out  1  MCB read FIFO pop.
- p_rd_data  in  32  MCB read data (first-word fall-through).
- p_rd_empty  in  1  MCB read FIFO empty.
- p_rd_overflow  in  1  MCB read overflow.
- p_rd_error  in  1  MCB read error.

Behaviour:
- Reset values: all outputs 0, except di_reg_datao = 0 and di_transfer_status = 0. State = IDLE, counters cleared.
- sel = (di_term_addr == TERM_ADDR). Every di_* input is ignored while sel = 0.
- Word count: nwords = (di_len + 3) >> 2, 30-bit.
- Addresses wrap modulo 2^30.
- States:
  - IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DATA, RD_FLUSH.
- IDLE:
  - sel & di_write_mode (rising edge) with nwords > 0: latch addr and remaining, clear wcnt, go to WR_FILL.
  - sel & di_read_req with nwords > 0: latch addr and remaining, go to RD_CMD.
  - nwords = 0: stay in IDLE, no command issued.
- WR_FILL:
  - di_write_rdy = !p_wr_full & (wcnt < BURST_LEN) & (remaining > 0).
  - p_wr_en = di_write & di_write_rdy, combinational. Each push: wcnt += 1, remaining -= 1.
  - Go to WR_CMD when wcnt = BURST_LEN, or remaining = 0 with wcnt > 0.
- WR_CMD:
  - di_write_rdy = 0.
  - Hold p_cmd_en = 1 until a cycle with !p_cmd_full; that cycle is the single strobe.
  - Command: instr 000, bl = wcnt-1, byte_addr = addr.
  - Then addr += wcnt*4, wcnt = 0; next state is WR_FILL if remaining > 0, else IDLE.
- RD_CMD:
  - Issue instr 001, bl = min(remaining, BURST_LEN)-1, with the same cmd_full rule as WR_CMD.
  - Load rcnt = burst words, addr += burst*4, remaining -= burst, go to RD_DATA.
- RD_DATA:
  - di_read_rdy = !p_rd_empty; di_reg_datao = p_rd_data, combinational.
  - p_rd_en = di_read & di_read_rdy. Each pop decrements rcnt.
  - rcnt = 0: go to RD_CMD if remaining > 0, else IDLE.
  - At most one read burst outstanding.
- Abort:
  - di_write_mode falls in WR_FILL: if wcnt > 0, go to WR_CMD with remaining forced to 0; else go to IDLE.
  - di_read_mode falls in RD_CMD: go to IDLE.
  - di_read_mode falls in RD_DATA: go to RD_FLUSH. RD_FLUSH pops (p_rd_en = !p_rd_empty) until rcnt = 0, then IDLE. di_read_rdy = 0 throughout.
- Simultaneous events: write has priority over read in IDLE. A di_read_req pulse that arrives outside IDLE is dropped.
- di_transfer_status (sticky bits):
  - [0] p_wr_underrun, [1] p_wr_error, [2] p_rd_overflow, [3] p_rd_error.
  - Cleared on entry to a new transfer from IDLE.
- Reset mid-operation: state is abandoned immediately and outputs return to reset values. MCB FIFO contents are not repaired; software re-issues the transfer.

Optional Feature:
- Macro: SDRAM_DI_STATS_EN.
- Defined: adds outputs stat_wr_cmds [15:0] and stat_rd_cmds [15:0].
  - Each increments on every accepted write or read command, saturating at 16'hFFFF, reset to 0.
  - di_transfer_status[15:8] = low 8 bits of stat_wr_cmds + stat_rd_cmds.
- Undefined: no stat ports; di_transfer_status[15:4] = 0.

Test Plan:
- Write di_reg_addr=0x100, di_len=128 (32 words), BURST_LEN=32 -> 32 p_wr_en pushes, then one p_cmd_en with instr 000, bl=31, addr=0x100.
- Write di_len=40 (10 words), BURST_LEN=4 -> commands bl=3 @0x0, bl=3 @0x10, bl=1 @0x20.
- Read addr=0x200, di_len=24, p_cmd_full held high 5 cycles -> p_cmd_en held until full drops, single read command bl=5 @0x200; 6 words delivered in order with di_read_rdy tracking !p_rd_empty.
- Write with p_wr_full asserted mid-burst -> di_write_rdy = 0 while full, no lost or duplicate words.
- Read aborted after 2 of 8 words -> RD_FLUSH pops remaining 6, returns to IDLE; next write proceeds normally.
- Pulse p_rd_error during read -> di_transfer_status = 16'h0008, held until next transfer start.
